// File: rtl/monitor_guard_pkg.sv
// Shared types and constants for the monitor-window Wishbone guard.
package monitor_guard_pkg;

  localparam int         TMR_W    = 8;
  localparam logic [7:0] VIOL_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    BLOCK = 2'd2,
    RESP  = 2'd3
  } state_e;

  // One downstream request as captured from the master.
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } mon_req_t;

endpackage

// File: rtl/monitor_guard_timer.sv
// Loadable down-counter bounding a forwarded transfer; zero marks the last wait cycle.
module monitor_guard_timer
  import monitor_guard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [TMR_W-1:0] init,
  output logic             zero
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= init;
    else if (en && count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/monitor_wb_guard.sv
// Wishbone guard in front of monitor memory: squashes locked writes to the protected
// region and bounds forwarded transfers. Optional MONITOR_GUARD_ERR_EN selects err responses.
module monitor_wb_guard
  import monitor_guard_pkg::*;
#(
  parameter int PROT_WORDS  = 512,
  parameter bit LOCK_STICKY = 1'b1,
  parameter int TIMEOUT     = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        write_lock,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] mon_adr_o,
  output logic [31:0] mon_dat_o,
  input  logic [31:0] mon_dat_i,
  output logic [3:0]  mon_sel_o,
  output logic        mon_stb_o,
  output logic        mon_cyc_o,
  output logic        mon_we_o,
  input  logic        mon_ack_i,
  output logic        lock_active_o,
  output logic [7:0]  viol_count_o,
  output logic [31:0] viol_adr_o
);

  localparam logic [29:0]      PROT_LIM = 30'(PROT_WORDS);
  // Timer holds the wait cycles remaining after the current one, so TIMEOUT
  // is exactly the number of cycles mon_stb_o stays high without an ack.
  localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(TIMEOUT - 1);

  state_e      state_q, state_d;
  mon_req_t    req_q, req_d;
  logic        act_q, act_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rdata_q, rdata_d;
  logic        to_q, to_d;
  logic        abort_q, abort_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] vadr_q, vadr_d;
  logic        lock_q;

  logic        prot, accept, live, fail;
  logic        tmr_load, tmr_en, tmr_zero;

  assign prot = (wb_adr_i[31:2] < PROT_LIM);
  // A response still on the bus is the master's old stb, not a new request.
  assign accept = wb_cyc_i && wb_stb_i && !ack_q && !err_q;
  assign live   = wb_cyc_i && !abort_q;

  monitor_guard_timer u_timer (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .load (tmr_load),
    .en   (tmr_en),
    .init (TMR_INIT),
    .zero (tmr_zero)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      lock_q <= 1'b0;
    else if (LOCK_STICKY)
      lock_q <= lock_q | write_lock;
    else
      lock_q <= write_lock;
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    act_d    = act_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dat_d    = '0;
    rdata_d  = rdata_q;
    to_d     = to_q;
    abort_d  = abort_q;
    cnt_d    = cnt_q;
    vadr_d   = vadr_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    fail     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          abort_d = 1'b0;
          if (wb_we_i && lock_q && prot) begin
            state_d = BLOCK;
            if (cnt_q != VIOL_MAX)
              cnt_d = cnt_q + 1'b1;
            if (cnt_q == '0)
              vadr_d = wb_adr_i;
          end else begin
            state_d   = FWD;
            act_d     = 1'b1;
            req_d.adr = wb_adr_i;
            req_d.dat = wb_dat_i;
            req_d.sel = wb_sel_i;
            req_d.we  = wb_we_i;
            tmr_load  = 1'b1;
          end
        end
      end
      FWD: begin
        tmr_en = 1'b1;
        if (!wb_cyc_i)
          abort_d = 1'b1;
        // Ack takes priority over expiry in the same cycle.
        if (mon_ack_i) begin
          state_d = RESP;
          act_d   = 1'b0;
          rdata_d = req_q.we ? '0 : mon_dat_i;
          to_d    = 1'b0;
        end else if (tmr_zero) begin
          state_d = RESP;
          act_d   = 1'b0;
          rdata_d = '0;
          to_d    = 1'b1;
        end
      end
      BLOCK: begin
        state_d = IDLE;
        fail    = live;
      end
      RESP: begin
        state_d = IDLE;
        if (live) begin
          if (to_q) begin
            fail = 1'b1;
          end else begin
            ack_d = 1'b1;
            dat_d = rdata_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef MONITOR_GUARD_ERR_EN
    if (fail) err_d = 1'b1;
`else
    if (fail) ack_d = 1'b1;
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      act_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      rdata_q <= '0;
      to_q    <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
      vadr_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      act_q   <= act_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      to_q    <= to_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
      vadr_q  <= vadr_d;
    end
  end

  assign mon_adr_o     = req_q.adr;
  assign mon_dat_o     = req_q.dat;
  assign mon_sel_o     = req_q.sel;
  assign mon_we_o      = req_q.we;
  assign mon_cyc_o     = act_q;
  assign mon_stb_o     = act_q;
  assign wb_ack_o      = ack_q;
  assign wb_dat_o      = dat_q;
  assign lock_active_o = lock_q;
  assign viol_count_o  = cnt_q;
  assign viol_adr_o    = vadr_q;

`ifdef MONITOR_GUARD_ERR_EN
  assign wb_err_o = err_q;
`else
  assign wb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_monitor_wb_guard.sv
// Directed bench for monitor_wb_guard with a small Wishbone memory model (TIMEOUT=4).
module tb_monitor_wb_guard;

  localparam int PROT_WORDS = 512;
  localparam int TIMEOUT    = 4;
`ifdef MONITOR_GUARD_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        write_lock = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] mon_adr_o, mon_dat_o, mon_dat_i;
  logic [3:0]  mon_sel_o;
  logic        mon_stb_o, mon_cyc_o, mon_we_o, mon_ack_i;
  logic        lock_active_o;
  logic [7:0]  viol_count_o;
  logic [31:0] viol_adr_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 sys_clk = ~sys_clk;

  monitor_wb_guard #(
    .PROT_WORDS (PROT_WORDS),
    .LOCK_STICKY(1'b1),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .write_lock   (write_lock),
    .wb_adr_i     (wb_adr_i),
    .wb_dat_i     (wb_dat_i),
    .wb_dat_o     (wb_dat_o),
    .wb_sel_i     (wb_sel_i),
    .wb_stb_i     (wb_stb_i),
    .wb_cyc_i     (wb_cyc_i),
    .wb_we_i      (wb_we_i),
    .wb_ack_o     (wb_ack_o),
    .wb_err_o     (wb_err_o),
    .mon_adr_o    (mon_adr_o),
    .mon_dat_o    (mon_dat_o),
    .mon_dat_i    (mon_dat_i),
    .mon_sel_o    (mon_sel_o),
    .mon_stb_o    (mon_stb_o),
    .mon_cyc_o    (mon_cyc_o),
    .mon_we_o     (mon_we_o),
    .mon_ack_i    (mon_ack_i),
    .lock_active_o(lock_active_o),
    .viol_count_o (viol_count_o),
    .viol_adr_o   (viol_adr_o)
  );

  // Memory model: acks once mon_stb_o has been high for mem_dly earlier cycles.
  logic [31:0] mem [0:1023];
  logic        mem_en  = 1'b1;
  int          mem_dly = 0;
  int          stb_age = 0;

  always @(posedge sys_clk) stb_age <= mon_stb_o ? stb_age + 1 : 0;

  assign mon_ack_i = mem_en && mon_cyc_o && mon_stb_o && (stb_age >= mem_dly);
  assign mon_dat_i = mem[mon_adr_o[11:2]];

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      mem[4]  <= 32'h12345678;
      mem[16] <= 32'hCAFE0001;
    end else if (mon_ack_i && mon_we_o) begin
      for (int b = 0; b < 4; b++)
        if (mon_sel_o[b]) mem[mon_adr_o[11:2]][8*b +: 8] <= mon_dat_o[8*b +: 8];
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One master transfer; cycle 0 is the cycle stb is first driven.
  task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input bit keep, input int exp_lat,
                      input bit exp_fail, input logic [31:0] exp_dat, input int exp_stb);
    int lat, stb_n;
    bit done;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = 4'hF;
    lat = 0; stb_n = 0; done = 1'b0;
    while (!done && lat < 20) begin
      step();
      lat++;
      if (mon_stb_o) stb_n++;
      if (wb_ack_o || wb_err_o) done = 1'b1;
    end
    if (!done) lat = 99;
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " ack"},     32'(wb_ack_o), 32'(!(exp_fail && ERR_EN)));
    chk({tag, " err"},     32'(wb_err_o), 32'(exp_fail && ERR_EN));
    chk({tag, " rdata"},   wb_dat_o, exp_dat);
    chk({tag, " mon_stb cycles"}, 32'(stb_n), 32'(exp_stb));
    step();
    chk({tag, " response width"}, 32'(wb_ack_o | wb_err_o), 32'd0);
    if (!keep) begin
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    end
  endtask

  initial begin
    int stb_n;
    bit any_resp;

    // Reset state
    repeat (3) step();
    chk("rst ack",        32'(wb_ack_o), 32'd0);
    chk("rst err",        32'(wb_err_o), 32'd0);
    chk("rst mon_stb",    32'(mon_stb_o), 32'd0);
    chk("rst mon_cyc",    32'(mon_cyc_o), 32'd0);
    chk("rst lock",       32'(lock_active_o), 32'd0);
    chk("rst viol_count", 32'(viol_count_o), 32'd0);
    chk("rst viol_adr",   viol_adr_o, 32'd0);
    chk("rst rdata",      wb_dat_o, 32'd0);
    sys_rst = 1'b0;
    step();

    // Unlocked traffic
    xfer("rd 0x10", 1'b0, 32'h10, 32'h0, 1'b0, 3, 1'b0, 32'h12345678, 1);
    xfer("wr 0x20", 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, 3, 1'b0, 32'h0, 1);
    xfer("rd 0x20", 1'b0, 32'h20, 32'h0, 1'b0, 3, 1'b0, 32'hA5A5A5A5, 1);

    // Back-to-back: master keeps cyc&stb in the cycle after ack
    xfer("b2b first",  1'b0, 32'h10, 32'h0, 1'b1, 3, 1'b0, 32'h12345678, 1);
    xfer("b2b second", 1'b0, 32'h20, 32'h0, 1'b0, 3, 1'b0, 32'hA5A5A5A5, 1);

    // Lock pulse, sticky afterwards
    write_lock = 1'b1;
    step();
    write_lock = 1'b0;
    step();
    chk("lock after pulse", 32'(lock_active_o), 32'd1);
    step();
    chk("lock sticky", 32'(lock_active_o), 32'd1);

    // Locked protected write is squashed
    xfer("locked wr 0x40", 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 2, 1'b1, 32'h0, 0);
    chk("viol_count first", 32'(viol_count_o), 32'd1);
    chk("viol_adr first",   viol_adr_o, 32'h40);
    xfer("rd 0x40 old", 1'b0, 32'h40, 32'h0, 1'b0, 3, 1'b0, 32'hCAFE0001, 1);

    // Word PROT_WORDS is outside the protected region
    xfer("locked wr 0x800", 1'b1, 32'h800, 32'h11112222, 1'b0, 3, 1'b0, 32'h0, 1);
    chk("viol_count unprot", 32'(viol_count_o), 32'd1);
    xfer("rd 0x800", 1'b0, 32'h800, 32'h0, 1'b0, 3, 1'b0, 32'h11112222, 1);

    // 260 more squashed writes: count saturates, first address sticks
    for (int i = 0; i < 260; i++) begin
      xfer("sat wr 0x0", 1'b1, 32'h0, i, 1'b0, 2, 1'b1, 32'h0, 0);
      if (i == 252) chk("viol_count 254", 32'(viol_count_o), 32'd254);
    end
    chk("viol_count sat", 32'(viol_count_o), 32'd255);
    chk("viol_adr sticky", viol_adr_o, 32'h40);

    // Timeout: memory never acks
    mem_en = 1'b0;
    xfer("timeout rd", 1'b0, 32'h10, 32'h0, 1'b0, TIMEOUT + 2, 1'b1, 32'h0, TIMEOUT);
    mem_en = 1'b1;

    // Ack in the last wait cycle beats the timeout
    mem_dly = TIMEOUT - 1;
    xfer("ack at expiry", 1'b0, 32'h10, 32'h0, 1'b0, TIMEOUT + 2, 1'b0, 32'h12345678, TIMEOUT);

    // Master abort: downstream completes, no response
    mem_dly = 2;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h10;
    step();
    stb_n = mon_stb_o ? 1 : 0;
    any_resp = wb_ack_o | wb_err_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mon_stb_o) stb_n++;
      if (wb_ack_o || wb_err_o) any_resp = 1'b1;
    end
    chk("abort mon_stb cycles", 32'(stb_n), 32'd3);
    chk("abort no response", 32'(any_resp), 32'd0);
    mem_dly = 0;
    xfer("rd after abort", 1'b0, 32'h10, 32'h0, 1'b0, 3, 1'b0, 32'h12345678, 1);

    // Reset during FWD
    mem_en = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h10;
    step();
    step();
    chk("pre-rst mon_stb", 32'(mon_stb_o), 32'd1);
    sys_rst = 1'b1;
    step();
    chk("midrst mon_stb",    32'(mon_stb_o), 32'd0);
    chk("midrst mon_cyc",    32'(mon_cyc_o), 32'd0);
    chk("midrst ack",        32'(wb_ack_o), 32'd0);
    chk("midrst err",        32'(wb_err_o), 32'd0);
    chk("midrst lock",       32'(lock_active_o), 32'd0);
    chk("midrst viol_count", 32'(viol_count_o), 32'd0);
    chk("midrst viol_adr",   viol_adr_o, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    sys_rst = 1'b0;
    mem_en = 1'b1;
    any_resp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (wb_ack_o || wb_err_o) any_resp = 1'b1;
    end
    chk("post-rst no response", 32'(any_resp), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
